// File: rtl/mux4_rr_arbiter_if.sv
// Bus between four requesters and the round-robin 4:1 select arbiter.
//   req    : request vector, bit i = requester i
//   d0..d3 : per-requester data, DW bits each
//   s1, s0 : registered select pair, equal to the granted index
//   gnt    : registered one-hot grant (zero when idle)
//   busy   : high while any grant is active
//   y      : data of the granted requester, zero when idle
// The master side is the requester/system side; the slave side is the arbiter.
interface mux4_rr_arbiter_if #(
  parameter int DW = 1
);
  logic [3:0]    req;
  logic [DW-1:0] d0;
  logic [DW-1:0] d1;
  logic [DW-1:0] d2;
  logic [DW-1:0] d3;
  logic          s1;
  logic          s0;
  logic [3:0]    gnt;
  logic          busy;
  logic [DW-1:0] y;

  modport master (
    output req, d0, d1, d2, d3,
    input  s1, s0, gnt, busy, y
  );

  modport slave (
    input  req, d0, d1, d2, d3,
    output s1, s0, gnt, busy, y
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 select path between four requesters.
// The winner is the first set request scanning circularly from a 2-bit
// priority pointer. A granted requester keeps the grant while it requests,
// limited to MAX_HOLD consecutive cycles when others are waiting. Grant,
// select pair and busy are registered (one cycle latency); y is a
// combinational select of the granted data, gated to zero when idle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux4_rr_arbiter_if.slave (req, d0..d3 in; s1, s0, gnt, busy, y out)
module mux4_rr_arbiter #(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_arbiter_if.slave   bus
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [1:0]    sel_r, sel_s;
  logic [1:0]    ptr_r, ptr_s;
  logic [HW-1:0] hold_r, hold_s;
  logic [3:0]    gnt_r, gnt_s;
  logic          busy_r, busy_s;
  logic [3:0]    others_s;
  logic [1:0]    win_s;

  // First set request bit scanning circularly from start.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Next-state and registered-output decode.
  always_comb begin
    state_s  = state_r;
    sel_s    = sel_r;
    ptr_s    = ptr_r;
    hold_s   = hold_r;
    gnt_s    = gnt_r;
    busy_s   = busy_r;
    // gnt_r is the one-hot of the current owner, so this masks it out.
    others_s = bus.req & ~gnt_r;
    // ptr_r is owner+1 while granted, so this is also the hand-over winner.
    win_s    = rr_pick(bus.req, ptr_r);

    case (state_r)
      ST_IDLE: begin
        if (bus.req != 4'b0000) begin
          state_s = ST_GRANT;
          sel_s   = win_s;
          gnt_s   = 4'b0001 << win_s;
          busy_s  = 1'b1;
          ptr_s   = win_s + 2'd1;
          hold_s  = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (bus.req[sel_r] && ((others_s == 4'b0000) || (hold_r < HOLD_LAST))) begin
          // Keep the grant; the counter saturates when nobody else waits.
          hold_s = (hold_r == HOLD_LAST) ? hold_r : hold_r + HW'(1);
        end else if (others_s != 4'b0000) begin
          // Direct hand-over, no idle bubble.
          sel_s  = win_s;
          gnt_s  = 4'b0001 << win_s;
          busy_s = 1'b1;
          ptr_s  = win_s + 2'd1;
          hold_s = '0;
        end else begin
          // Select pair deliberately keeps its last value.
          state_s = ST_IDLE;
          gnt_s   = 4'b0000;
          busy_s  = 1'b0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = 4'b0000;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      sel_r   <= 2'b00;
      ptr_r   <= 2'b00;
      hold_r  <= '0;
      gnt_r   <= 4'b0000;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sel_r   <= sel_s;
      ptr_r   <= ptr_s;
      hold_r  <= hold_s;
      gnt_r   <= gnt_s;
      busy_r  <= busy_s;
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.s1   = sel_r[1];
  assign bus.s0   = sel_r[0];
  assign bus.busy = busy_r;

  // Output data select on the registered select pair, zero when idle.
  always_comb begin
    bus.y = '0;
    if (busy_r) begin
      case (sel_r)
        2'd0:    bus.y = bus.d0;
        2'd1:    bus.y = bus.d1;
        2'd2:    bus.y = bus.d2;
        2'd3:    bus.y = bus.d3;
        default: bus.y = '0;
      endcase
    end else begin
      bus.y = '0;
    end
  end

endmodule
